// File: rtl/vending_pkg.sv
// Shared coin codes, cent values and FSM state encoding
// for the vending machine and its coin input conditioner.
package vending_pkg;

  typedef logic [2:0] coin_t;

  localparam coin_t COIN_NONE    = 3'd0;
  localparam coin_t COIN_NICKEL  = 3'd1;
  localparam coin_t COIN_DIME    = 3'd2;
  localparam coin_t COIN_QUARTER = 3'd3;
  localparam coin_t COIN_DOLLAR  = 3'd4;

  localparam logic [6:0] CENTS_NICKEL  = 7'd5;
  localparam logic [6:0] CENTS_DIME    = 7'd10;
  localparam logic [6:0] CENTS_QUARTER = 7'd25;
  localparam logic [6:0] CENTS_DOLLAR  = 7'd100;

  localparam logic [11:0] TALLY_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HOLD,
    S_WAIT_RELEASE
  } state_t;

  function automatic logic is_onehot(input logic [3:0] b);
    return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] b);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (b[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic coin_t idx_coin(input logic [1:0] idx);
    coin_t c;
    unique case (idx)
      2'd0: c = COIN_NICKEL;
      2'd1: c = COIN_DIME;
      2'd2: c = COIN_QUARTER;
      2'd3: c = COIN_DOLLAR;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] idx_cents(input logic [1:0] idx);
    logic [6:0] v;
    unique case (idx)
      2'd0: v = CENTS_NICKEL;
      2'd1: v = CENTS_DIME;
      2'd2: v = CENTS_QUARTER;
      2'd3: v = CENTS_DOLLAR;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_input_conditioner_if.sv
// Button/coin bundle between the coin slot and the vending machine.
// COIN_TALLY_EN adds the running cent tally.
interface coin_input_conditioner_if;
  import vending_pkg::*;

  logic [3:0] btn_raw;
  coin_t      coin;
  logic       reject;
  logic       busy;
`ifdef COIN_TALLY_EN
  logic [11:0] tally_cents;
`endif

  modport slave (
    input  btn_raw,
    output coin,
    output reject,
`ifdef COIN_TALLY_EN
    output tally_cents,
`endif
    output busy
  );

  modport master (
    output btn_raw,
    input  coin,
    input  reject,
`ifdef COIN_TALLY_EN
    input  tally_cents,
`endif
    input  busy
  );

endinterface

// File: rtl/coin_input_conditioner_btn_sync.sv
// Two-flop synchronizer for a bus of independent
// asynchronous bits, with synchronous reset.
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // shift raw bits through two flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces coin buttons into held coin codes with multi-press reject.
// Optional COIN_TALLY_EN adds a saturating cent tally output.
module coin_input_conditioner
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 3
) (
  input logic                     clk50,
  input logic                     reset,
  coin_input_conditioner_if.slave bus
);

  localparam int MAXC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                        DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [3:0]    btn_s;
  logic [3:0]    cap_oh;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  coin_t         coin_q, coin_d;
  logic          reject_q, reject_d;

  btn_sync #(.W(4)) u_sync (
    .clk_i (clk50),
    .rst_i (reset),
    .d_i   (bus.btn_raw),
    .q_o   (btn_s)
  );

  assign cap_oh = 4'b0001 << idx_q;

  // next state, counter and registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    coin_d   = coin_q;
    reject_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        coin_d = COIN_NONE;
        if (is_onehot(btn_s)) begin
          state_d = S_DEBOUNCE;
          cnt_d   = CW'(1);
          idx_d   = onehot_idx(btn_s);
        end else if (btn_s != 4'd0) begin
          reject_d = 1'b1;
          state_d  = S_WAIT_RELEASE;
          cnt_d    = '0;
        end
      end
      S_DEBOUNCE: begin
        if (btn_s != cap_oh) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          coin_d  = idx_coin(idx_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = S_WAIT_RELEASE;
          cnt_d   = '0;
          coin_d  = COIN_NONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_RELEASE: begin
        if (btn_s != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // state and output registers; reset waits for release
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q  <= S_WAIT_RELEASE;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
    end
  end

  assign bus.coin   = coin_q;
  assign bus.reject = reject_q;
  assign bus.busy   = (state_q != S_IDLE);

`ifdef COIN_TALLY_EN
  logic [11:0] tally_q, tally_d;
  logic [12:0] tally_sum;

  // add coin value on each HOLD entry, saturating
  always_comb begin
    tally_sum = {1'b0, tally_q} + 13'(idx_cents(idx_q));
    tally_d   = tally_q;
    if (state_q == S_DEBOUNCE && state_d == S_HOLD)
      tally_d = (tally_sum > {1'b0, TALLY_MAX}) ?
                TALLY_MAX : tally_sum[11:0];
  end

  // tally register
  always_ff @(posedge clk50) begin
    if (reset) tally_q <= '0;
    else       tally_q <= tally_d;
  end

  assign bus.tally_cents = tally_q;
`endif

endmodule
